ring_out_arbiter: RTL and testbench

//  Output-channel arbiter/scheduler for one direction of a gold-ring router node.
//  - Shares one outbound ring link between two requesters: ring pass-through traffic and PE injection.
//  - Owns the even/odd polarity phase: VC[polarity] drains onto the link while VC[~polarity] is filled internally.
//  - Holds a one-entry output slot per VC and performs round-robin arbitration per VC.

---
 rtl/ring_out_if.sv | 39 +++
 rtl/ring_out_arbiter.sv | 119 +++++++++++
 tb/tb_ring_out_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_out_if.sv
// ring_out_if
//   Bundles the two requester channels (ring pass-through, PE injection) and
//   the outbound link of one ring direction.
//
//   Handshakes:
//     request side : a requester raises *_req with *_data and holds both
//                    stable until *_gnt is seen high. *_gnt is a single-cycle
//                    combinational pulse, and the packet is taken at the
//                    rising edge that ends that cycle.
//     link side    : out_so/out_do are valid/data and out_ri is ready. A
//                    packet moves on a rising edge where out_so & out_ri.
//                    While out_ri=0 the packet on out_do stays put.
//
//   Modports:
//     master : environment side (requesters and the downstream link)
//     slave  : arbiter side
interface ring_out_if #(
  parameter int DATA_W = 64
);
  logic              ring_req;
  logic [DATA_W-1:0] ring_data;
  logic              ring_gnt;
  logic              pe_req;
  logic [DATA_W-1:0] pe_data;
  logic              pe_gnt;
  logic              out_so;
  logic              out_ri;
  logic [DATA_W-1:0] out_do;

  modport master (
    output ring_req, ring_data, pe_req, pe_data, out_ri,
    input  ring_gnt, pe_gnt, out_so, out_do
  );

  modport slave (
    input  ring_req, ring_data, pe_req, pe_data, out_ri,
    output ring_gnt, pe_gnt, out_so, out_do
  );
endinterface

// File: rtl/ring_out_arbiter.sv
// ring_out_arbiter
//   Output-channel scheduler for one direction of a gold-ring router node.
//   The outbound link is time-shared between two virtual channels by a
//   polarity bit that toggles every cycle. VC[polarity] drains its one-entry
//   slot onto the link, while VC[~polarity] may accept one packet from the
//   ring or the PE. When both compete, a per-VC round-robin bit picks the
//   winner.
//
//   Ports:
//     clk_i      clock, rising edge
//     reset_ni   asynchronous active-low reset
//     bus        ring_out_if.slave: ring/PE requests + grants, link so/ri/do
//     polarity_o current phase; VC being driven on the link this cycle
//     dir_err_o  registered: a valid request carried the wrong direction bit
module ring_out_arbiter #(
  parameter int   DATA_W  = 64,
  parameter int   VC_BIT  = 63,
  parameter int   DIR_BIT = 62,
  parameter int   HOP_LSB = 48,
  parameter int   HOP_W   = 8,
  parameter logic DIR     = 1'b0
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  ring_out_if.slave      bus,
  output logic           polarity_o,
  output logic           dir_err_o
);

  logic                   polarity_q, polarity_d;
  logic [1:0]             slot_full_q, slot_full_d;
  logic [1:0][DATA_W-1:0] slot_data_q, slot_data_d;
  // rr_q[v] = 1 means the PE wins a tie on VC v; 0 means the ring wins.
  logic [1:0]             rr_q, rr_d;
  logic                   dir_err_q, dir_err_d;

  logic              p, q;
  logic              ring_dir_bad, pe_dir_bad;
  logic              ring_elig, pe_elig;
  logic              ring_gnt, pe_gnt;
  logic [DATA_W-1:0] ring_pkt;

  always_comb begin
    p = polarity_q;
    q = ~polarity_q;

    ring_dir_bad = (bus.ring_data[DIR_BIT] != DIR);
    pe_dir_bad   = (bus.pe_data[DIR_BIT] != DIR);
    // Only a request for the VC in its fill phase may compete. A request
    // for the draining VC waits one cycle for its turn.
    ring_elig = bus.ring_req && !ring_dir_bad && (bus.ring_data[VC_BIT] == q);
    pe_elig   = bus.pe_req && !pe_dir_bad && (bus.pe_data[VC_BIT] == q);

    // A ring packet has covered one more hop, so its hop field is halved.
    ring_pkt = bus.ring_data;
    ring_pkt[HOP_LSB +: HOP_W] = bus.ring_data[HOP_LSB +: HOP_W] >> 1;

    ring_gnt = 1'b0;
    pe_gnt   = 1'b0;
    // Slot occupancy is taken from the start of the cycle. A slot that
    // drains this cycle belongs to the other VC, so it cannot block this.
    if (!slot_full_q[q]) begin
      if (ring_elig && pe_elig) begin
        if (rr_q[q]) pe_gnt = 1'b1;
        else         ring_gnt = 1'b1;
      end else if (ring_elig) begin
        ring_gnt = 1'b1;
      end else if (pe_elig) begin
        pe_gnt = 1'b1;
      end
    end

    polarity_d  = ~polarity_q;
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    rr_d        = rr_q;

    if (slot_full_q[p] && bus.out_ri) slot_full_d[p] = 1'b0;

    // The pointer moves to the loser so that the loser wins the next tie.
    if (ring_gnt) begin
      slot_full_d[q] = 1'b1;
      slot_data_d[q] = ring_pkt;
      rr_d[q]        = 1'b1;
    end else if (pe_gnt) begin
      slot_full_d[q] = 1'b1;
      slot_data_d[q] = bus.pe_data;
      rr_d[q]        = 1'b0;
    end

    dir_err_d = (bus.ring_req && ring_dir_bad) || (bus.pe_req && pe_dir_bad);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      polarity_q  <= 1'b0;
      slot_full_q <= '0;
      slot_data_q <= '0;
      rr_q        <= '0;
      dir_err_q   <= 1'b0;
    end else begin
      polarity_q  <= polarity_d;
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      rr_q        <= rr_d;
      dir_err_q   <= dir_err_d;
    end
  end

  // The link outputs come straight from the registers. Because of that,
  // an async reset clears out_so without waiting for a clock edge.
  assign bus.ring_gnt = ring_gnt;
  assign bus.pe_gnt   = pe_gnt;
  assign bus.out_so   = slot_full_q[p];
  assign bus.out_do   = slot_full_q[p] ? slot_data_q[p] : '0;
  assign polarity_o   = polarity_q;
  assign dir_err_o    = dir_err_q;

endmodule

// File: tb/tb_ring_out_arbiter.sv
// tb_ring_out_arbiter
//   Directed bench for ring_out_arbiter. It drives inputs one time unit
//   after each rising edge and checks one or two units later. Expected
//   values are worked out by hand from the packet fields. The bench also
//   tracks the expected polarity on its own.
module tb_ring_out_arbiter;
  localparam int W = 64;

  logic clk;
  logic rst_n;
  logic polarity;
  logic dir_err;
  int   n_checks;
  int   n_fail;
  logic exp_pol;

  ring_out_if #(.DATA_W(W)) bus ();

  ring_out_arbiter #(
    .DATA_W(W), .VC_BIT(63), .DIR_BIT(62), .HOP_LSB(48), .HOP_W(8), .DIR(1'b0)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .bus        (bus),
    .polarity_o (polarity),
    .dir_err_o  (dir_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic vc, input logic dir,
                                      input logic [7:0] hop, input logic [47:0] pay);
    return {vc, dir, 6'b0, hop, pay};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge. The bench polarity toggles only while out of reset.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) exp_pol = ~exp_pol;
    chk("polarity", {63'b0, polarity}, {63'b0, exp_pol});
  endtask

  task automatic chk_gnt(input string tag, input logic rg, input logic pg);
    chk({tag, "_ring_gnt"}, {63'b0, bus.ring_gnt}, {63'b0, rg});
    chk({tag, "_pe_gnt"},   {63'b0, bus.pe_gnt},   {63'b0, pg});
  endtask

  task automatic chk_out(input string tag, input logic so, input logic [W-1:0] d);
    chk({tag, "_out_so"}, {63'b0, bus.out_so}, {63'b0, so});
    chk({tag, "_out_do"}, bus.out_do, d);
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0] p2, r3_in, r3_out, p3, p4, p0, r4_in, r4_out, p6, bad;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_pol  = 1'b0;
    rst_n    = 1'b1;
    bus.ring_req  = 1'b0;
    bus.ring_data = '0;
    bus.pe_req    = 1'b0;
    bus.pe_data   = '0;
    bus.out_ri    = 1'b1;

    p2     = mk(1'b1, 1'b0, 8'h0F, 48'h1);
    r3_in  = mk(1'b1, 1'b0, 8'h0F, 48'hAAAA);
    r3_out = mk(1'b1, 1'b0, 8'h07, 48'hAAAA);
    p3     = mk(1'b1, 1'b0, 8'h33, 48'hBBBB);
    p4     = mk(1'b1, 1'b0, 8'h11, 48'h44);
    p0     = mk(1'b0, 1'b0, 8'h22, 48'h66);
    r4_in  = mk(1'b1, 1'b0, 8'hF0, 48'h55);
    r4_out = mk(1'b1, 1'b0, 8'h78, 48'h55);
    p6     = mk(1'b1, 1'b0, 8'h01, 48'h77);
    bad    = mk(1'b1, 1'b1, 8'h05, 48'h99);

    // 1. Reset values, then free-running polarity.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_polarity", {63'b0, polarity}, '0);
    chk_out("rst", 1'b0, '0);
    chk_gnt("rst", 1'b0, 1'b0);
    chk("rst_dir_err", {63'b0, dir_err}, '0);
    repeat (3) tick();
    chk_out("rst_hold", 1'b0, '0);
    rst_n = 1'b1;
    repeat (4) tick();                       // polarity 1,0,1,0

    // 2. Single PE VC1 packet: grant at pol0, on the link at pol1.
    bus.pe_req = 1'b1; bus.pe_data = p2;
    #1 chk_gnt("t2_grant", 1'b0, 1'b1);
    chk_out("t2_before", 1'b0, '0);
    tick();                                  // pol1
    bus.pe_req = 1'b0;
    #1 chk_out("t2_send", 1'b1, p2);
    chk_gnt("t2_idle", 1'b0, 1'b0);
    tick();                                  // pol0
    chk_out("t2_pol0", 1'b0, '0);
    tick();                                  // pol1
    chk_out("t2_freed", 1'b0, '0);

    // 3. Ring and PE both on VC1: grants alternate, ring hop halved.
    bus.ring_req = 1'b1; bus.ring_data = r3_in;
    bus.pe_req   = 1'b1; bus.pe_data   = p3;
    #1 chk_gnt("t3_wrong_phase", 1'b0, 1'b0);
    tick();                                  // pol0
    chk_gnt("t3_g1_ring", 1'b1, 1'b0);
    tick();                                  // pol1
    chk_out("t3_s1", 1'b1, r3_out);
    chk_gnt("t3_s1", 1'b0, 1'b0);
    tick();                                  // pol0
    chk_gnt("t3_g2_pe", 1'b0, 1'b1);
    tick();                                  // pol1
    chk_out("t3_s2", 1'b1, p3);
    tick();                                  // pol0
    chk_gnt("t3_g3_ring", 1'b1, 1'b0);
    tick();                                  // pol1
    bus.ring_req = 1'b0; bus.pe_req = 1'b0;
    chk_out("t3_s3", 1'b1, r3_out);
    tick();                                  // pol0
    chk_out("t3_empty", 1'b0, '0);

    // 4. Link stalled on VC1 while VC0 keeps flowing.
    bus.out_ri = 1'b0;
    bus.pe_req = 1'b1; bus.pe_data = p4;
    #1 chk_gnt("t4_p4", 1'b0, 1'b1);
    tick();                                  // pol1
    bus.pe_data = p0;                        // next PE packet is VC0
    bus.ring_req = 1'b1; bus.ring_data = r4_in;
    #1 chk_out("t4_stall1", 1'b1, p4);
    chk_gnt("t4_p0", 1'b0, 1'b1);
    tick();                                  // pol0
    bus.pe_req = 1'b0;
    bus.out_ri = 1'b1;
    #1 chk_out("t4_vc0", 1'b1, p0);
    chk_gnt("t4_blocked1", 1'b0, 1'b0);
    tick();                                  // pol1
    bus.out_ri = 1'b0;
    #1 chk_out("t4_stall2", 1'b1, p4);
    chk_gnt("t4_pol1", 1'b0, 1'b0);
    tick();                                  // pol0
    chk_out("t4_vc0_gone", 1'b0, '0);
    chk_gnt("t4_blocked2", 1'b0, 1'b0);
    bus.out_ri = 1'b1;
    tick();                                  // pol1
    chk_out("t4_release", 1'b1, p4);
    tick();                                  // pol0
    chk_gnt("t4_ring_now", 1'b1, 1'b0);
    tick();                                  // pol1
    bus.ring_req = 1'b0;
    chk_out("t4_r4", 1'b1, r4_out);
    tick();                                  // pol0

    // 5. Misrouted requests: never granted, dir_err follows one cycle later.
    bus.pe_req = 1'b1; bus.pe_data = bad;
    #1 chk_gnt("t5_first", 1'b0, 1'b0);
    chk("t5_dir_err_pre", {63'b0, dir_err}, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_dir_err", {63'b0, dir_err}, 64'd1);
      chk_gnt("t5_never", 1'b0, 1'b0);
      chk("t5_out_so", {63'b0, bus.out_so}, '0);
    end
    bus.pe_req = 1'b0;
    tick();
    chk("t5_dir_err_clear", {63'b0, dir_err}, '0);
    bus.ring_req = 1'b1; bus.ring_data = bad;
    #1 chk_gnt("t5_ring_bad", 1'b0, 1'b0);
    tick();
    chk("t5_ring_dir_err", {63'b0, dir_err}, 64'd1);
    bus.ring_req = 1'b0;
    tick();
    chk("t5_ring_dir_clear", {63'b0, dir_err}, '0);

    // 6. Async reset while VC1 is on the link.
    if (exp_pol) tick();                     // align to pol0
    bus.out_ri = 1'b0;
    bus.pe_req = 1'b1; bus.pe_data = p6;
    #1 chk_gnt("t6_grant", 1'b0, 1'b1);
    tick();                                  // pol1
    bus.pe_req = 1'b0;
    #1 chk_out("t6_full", 1'b1, p6);
    #2 rst_n = 1'b0;                          // mid-cycle, away from the edge
    exp_pol = 1'b0;
    #1 chk_out("t6_async", 1'b0, '0);
    chk("t6_pol_async", {63'b0, polarity}, '0);
    tick();                                  // held in reset
    rst_n = 1'b1;
    bus.out_ri = 1'b1;
    tick();                                  // pol1
    chk_out("t6_after1", 1'b0, '0);
    tick();                                  // pol0
    chk_out("t6_after2", 1'b0, '0);
    tick();                                  // pol1
    chk_out("t6_after3", 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
